// File: rtl/lenet_front_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lenet_front_pkg
// Description : Shared geometry constants and layer controller state codes
//               for the LeNet front (conv1) layer blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package lenet_front_pkg;

  localparam int DATA_WIDTH         = 12;
  localparam int FILTER_WIDTH       = 5;
  localparam int INPUT_WIDTH        = 32;
  localparam int OUTPUT_FEATURE_MAP = 6;
  localparam int OUT_WIDTH          = INPUT_WIDTH - FILTER_WIDTH + 1;
  localparam int OUT_DEPTH          = OUT_WIDTH * OUT_WIDTH;
  localparam int BUS_WIDTH          = OUTPUT_FEATURE_MAP * DATA_WIDTH;
  localparam int ADDR_WIDTH         = 10;
  localparam int POS_WIDTH          = 5;

  // One-hot layer controller state codes, shared with the address
  // generator and the layer controller.
  typedef logic [4:0] ctrl_state_t;

  localparam ctrl_state_t IDLE        = 5'b00001;
  localparam ctrl_state_t LOAD_W      = 5'b00010;
  localparam ctrl_state_t CALCULATION = 5'b00100;
  localparam ctrl_state_t DONE        = 5'b01000;

endpackage : lenet_front_pkg
`default_nettype wire

// File: rtl/relu_pack.sv
`default_nettype none
// ============================================================================
// Module      : relu_pack
// Description : Combinational per-channel ReLU over a packed bus of
//               two's-complement channel results. Negative channels become
//               zero; non-negative channels pass through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_pack #(
  parameter int DATA_WIDTH         = 12,
  parameter int OUTPUT_FEATURE_MAP = 6
) (
  input  logic [OUTPUT_FEATURE_MAP*DATA_WIDTH-1:0] packed_raw,
  output logic [OUTPUT_FEATURE_MAP*DATA_WIDTH-1:0] packed_relu
);

  // One independent clamp per channel slice; the sign bit alone decides.
  for (genvar k = 0; k < OUTPUT_FEATURE_MAP; k++) begin : g_ch
    assign packed_relu[k*DATA_WIDTH +: DATA_WIDTH] =
      packed_raw[k*DATA_WIDTH + DATA_WIDTH - 1] ? '0
                                                : packed_raw[k*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule : relu_pack
`default_nettype wire

// File: rtl/front_layer_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : front_layer_result_writer
// Description : Accepts packed conv1 results during CALCULATION, applies
//               ReLU and writes each pixel into the 28x28 output map RAM in
//               row-major order. Produces address, row/col, a completion
//               pulse and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module front_layer_result_writer
  import lenet_front_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            st,
  input  logic                  in_valid,
  input  logic [BUS_WIDTH-1:0]  in_data,
  output logic                  in_ready,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [BUS_WIDTH-1:0]  out_data,
  output logic [POS_WIDTH-1:0]  out_row,
  output logic [POS_WIDTH-1:0]  out_col,
  output logic                  layer_done,
  output logic                  overflow
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_RUN  = 2'd1;
  localparam logic [1:0] W_FULL = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(OUT_DEPTH - 1);
  localparam logic [POS_WIDTH-1:0]  c_last_col  = POS_WIDTH'(OUT_WIDTH - 1);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [POS_WIDTH-1:0]  r_row;
  logic [POS_WIDTH-1:0]  r_col;
  logic                  r_overflow;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BUS_WIDTH-1:0]  r_data;
  logic [POS_WIDTH-1:0]  r_out_row;
  logic [POS_WIDTH-1:0]  r_out_col;
  logic                  r_done;

  logic                  w_calc;
  logic                  w_clear;
  logic                  w_accept;
  logic                  w_last;
  logic [BUS_WIDTH-1:0]  w_relu;

  assign w_calc   = (st == CALCULATION);
  assign w_clear  = (st == IDLE);
  // Ready depends only on registered state, never on in_valid.
  assign in_ready = (r_state == W_RUN);
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == c_last_addr);

  relu_pack #(
    .DATA_WIDTH         (DATA_WIDTH),
    .OUTPUT_FEATURE_MAP (OUTPUT_FEATURE_MAP)
  ) u_relu (
    .packed_raw  (in_data),
    .packed_relu (w_relu)
  );

  // Writer FSM with the running pixel counter and row/col position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= W_IDLE;
      r_cnt      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_state    <= W_IDLE;
      r_cnt      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        W_IDLE: begin
          if (w_calc) r_state <= W_RUN;
        end
        W_RUN: begin
          if (!w_calc) begin
            // Abort: drop the partial map and wait for a fresh start.
            r_state <= W_IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end else if (w_accept) begin
            if (w_last) begin
              r_state <= W_FULL;
              r_cnt   <= '0;
              r_row   <= '0;
              r_col   <= '0;
            end else begin
              // Address advances by one; row/col track it without a multiply.
              r_cnt <= r_cnt + 1'b1;
              if (r_col == c_last_col) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        W_FULL: begin
          if (in_valid) r_overflow <= 1'b1;
        end
        default: r_state <= W_IDLE;
      endcase
    end
  end

  // Registered RAM write port: one cycle after each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
    end else begin
      r_we   <= w_accept & ~w_clear;
      r_done <= w_accept & w_calc & w_last;
      if (w_accept) begin
        r_addr    <= r_cnt;
        r_data    <= w_relu;
        r_out_row <= r_row;
        r_out_col <= r_col;
      end
    end
  end

  assign out_we     = r_we;
  assign out_addr   = r_addr;
  assign out_data   = r_data;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign layer_done = r_done;
  assign overflow   = r_overflow;

endmodule : front_layer_result_writer
`default_nettype wire

// File: tb/tb_front_layer_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_front_layer_result_writer
// Description : Scoreboard bench for front_layer_result_writer. Stimulus
//               pushes the expected RAM write for every beat it knows will
//               be accepted; a monitor pops and compares on each out_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_front_layer_result_writer;
  import lenet_front_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [4:0]            st;
  logic                  in_valid;
  logic [BUS_WIDTH-1:0]  in_data;
  logic                  in_ready;
  logic                  out_we;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [BUS_WIDTH-1:0]  out_data;
  logic [POS_WIDTH-1:0]  out_row;
  logic [POS_WIDTH-1:0]  out_col;
  logic                  layer_done;
  logic                  overflow;

  front_layer_result_writer dut (
    .clk        (clk),
    .rst        (rst),
    .st         (st),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .layer_done (layer_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [4:0]  row;
    logic [4:0]  col;
    logic [71:0] data;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_idx, m_row, m_col;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [71:0] relu_model(input logic [71:0] d);
    logic [71:0] r;
    logic [11:0] seg;
    r = '0;
    for (int k = 0; k < 6; k++) begin
      seg = d[k*12 +: 12];
      r[k*12 +: 12] = seg[11] ? 12'h000 : seg;
    end
    return r;
  endfunction

  // Channel 0 carries the pixel index; other channels a mix of signs.
  function automatic logic [71:0] beat_for(input int i);
    logic [71:0] d;
    for (int k = 0; k < 6; k++)
      d[k*12 +: 12] = (k == 0) ? 12'(i) : 12'(i * (k + 7) + k * 37);
    return d;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_row = 0; m_col = 0;
  endtask

  task automatic push_pixel(input logic [71:0] exp_data);
    exp_t e;
    e.addr = 10'(m_idx);
    e.row  = 5'(m_row);
    e.col  = 5'(m_col);
    e.data = exp_data;
    e.done = (m_idx == 783);
    exp_q.push_back(e);
    m_idx++;
    if (m_col == 27) begin m_col = 0; m_row++; end
    else m_col++;
  endtask

  task automatic step(input logic [4:0] s, input logic v, input logic [71:0] d);
    st = s; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (out_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {118'd0, out_addr}, 128'h3FF_DEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("addr", {118'd0, out_addr}, {118'd0, e.addr});
        check("row_col", {118'd0, out_row, out_col}, {118'd0, e.row, e.col});
        check("data", {56'd0, out_data}, {56'd0, e.data});
        check("done", {127'd0, layer_done}, {127'd0, e.done});
      end
    end else if (layer_done) begin
      check("done_without_we", {127'd0, layer_done}, 128'd0);
    end
  end

  initial begin
    logic [71:0] hand_in, hand_exp;
    int acc;
    rst = 1'b1; st = IDLE; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", {127'd0, out_we}, 128'd0);
    check("rst_addr", {118'd0, out_addr}, 128'd0);
    check("rst_ready", {127'd0, in_ready}, 128'd0);
    rst = 1'b0;

    // LOAD_W / DONE in idle: no effect; stray valid ignored, no overflow.
    step(LOAD_W, 1'b1, 72'h1);
    step(DONE, 1'b1, 72'h1);
    check("idle_ready", {127'd0, in_ready}, 128'd0);
    check("idle_ovf", {127'd0, overflow}, 128'd0);

    // Map 1: valid held high for a full map.
    step(CALCULATION, 1'b0, '0);
    check("run_ready", {127'd0, in_ready}, 128'd1);
    for (int i = 0; i < 784; i++) begin
      push_pixel(relu_model(beat_for(i)));
      step(CALCULATION, 1'b1, beat_for(i));
    end
    check("full_ready", {127'd0, in_ready}, 128'd0);
    // Three extra beats must be dropped and raise overflow.
    for (int i = 0; i < 3; i++) step(CALCULATION, 1'b1, 72'hFFF);
    check("ovf_set", {127'd0, overflow}, 128'd1);
    repeat (3) step(CALCULATION, 1'b0, '0);
    check("ovf_held", {127'd0, overflow}, 128'd1);
    step(IDLE, 1'b0, '0);
    check("ovf_cleared", {127'd0, overflow}, 128'd0);
    check("q_empty_map1", {96'd0, 32'(exp_q.size())}, 128'd0);

    // Map 2: random valid toggling, first pixel is the hand ReLU vector.
    model_reset();
    hand_in  = {12'h400, 12'h000, 12'h001, 12'hFFF, 12'h800, 12'h7FF};
    hand_exp = {12'h400, 12'h000, 12'h001, 12'h000, 12'h000, 12'h7FF};
    step(CALCULATION, 1'b0, '0);
    acc = 0;
    while (acc < 784) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [71:0] d;
        d = (acc == 0) ? hand_in : {$urandom, $urandom, $urandom};
        push_pixel((acc == 0) ? hand_exp : relu_model(d));
        step(CALCULATION, 1'b1, d);
        acc++;
      end else begin
        step(CALCULATION, 1'b0, {$urandom, $urandom, $urandom});
      end
    end
    step(CALCULATION, 1'b0, '0);
    check("q_empty_map2", {96'd0, 32'(exp_q.size())}, 128'd0);
    check("ovf_before_extra", {127'd0, overflow}, 128'd0);
    step(CALCULATION, 1'b1, 72'h5);
    step(CALCULATION, 1'b0, '0);
    check("ovf_map2", {127'd0, overflow}, 128'd1);
    step(IDLE, 1'b0, '0);

    // Abort after addr 100, then restart from address 0.
    model_reset();
    step(CALCULATION, 1'b0, '0);
    for (int i = 0; i < 101; i++) begin
      push_pixel(relu_model(beat_for(i)));
      step(CALCULATION, 1'b1, beat_for(i));
    end
    step(LOAD_W, 1'b0, '0);
    check("abort_ready", {127'd0, in_ready}, 128'd0);
    step(IDLE, 1'b0, '0);
    step(CALCULATION, 1'b0, '0);
    model_reset();
    for (int i = 0; i < 5; i++) begin
      push_pixel(relu_model(beat_for(i + 300)));
      step(CALCULATION, 1'b1, beat_for(i + 300));
    end
    check("pre_rst_we", {127'd0, out_we}, 128'd1);

    // Asynchronous reset mid-cycle while a write is on the port.
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_we", {127'd0, out_we}, 128'd0);
    check("arst_addr", {118'd0, out_addr}, 128'd0);
    check("arst_ovf", {127'd0, overflow}, 128'd0);
    check("arst_done", {127'd0, layer_done}, 128'd0);
    check("arst_ready", {127'd0, in_ready}, 128'd0);
    st = IDLE; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(IDLE, 1'b0, '0);
    check("q_empty_end", {96'd0, 32'(exp_q.size())}, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_front_layer_result_writer
`default_nettype wire

// File: doc/front_layer_result_writer.md
Name: front_layer_result_writer

Overview:
Write-side counterpart to the conv1 address generator.
- Accepts the packed 6-channel convolution results produced during the front layer's CALCULATION state.
- Applies per-channel ReLU and writes each pixel into the 28x28 output feature-map RAM in row-major order.
- Generates the RAM write address, row/col position, completion pulse and an overflow flag for the layer controller.

Parameters:
DATA_WIDTH, 12, bits per channel result
FILTER_WIDTH, 5, kernel width/height
INPUT_WIDTH, 32, input map width (= height)
OUTPUT_FEATURE_MAP, 6, channels packed per beat
OUT_WIDTH, INPUT_WIDTH-FILTER_WIDTH+1 (28), output map width (= height)
OUT_DEPTH, OUT_WIDTH*OUT_WIDTH (784), pixels per map
BUS_WIDTH, OUTPUT_FEATURE_MAP*DATA_WIDTH (72), packed result width
IDLE/LOAD_W/CALCULATION/DONE, 5'b00001/00010/00100/01000, layer controller state codes

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
st  in  5  layer controller state
in_valid  in  1  in_data holds one output pixel (all channels)
in_data  in  BUS_WIDTH  channel k in bits [k*DATA_WIDTH +: DATA_WIDTH], two's complement
in_ready  out  1  writer is accepting beats
out_we  out  1  RAM write enable
out_addr  out  10  RAM write address, 0..OUT_DEPTH-1
out_data  out  BUS_WIDTH  ReLU'd packed data
out_row  out  5  row of the pixel currently being written
out_col  out  5  column of the pixel currently being written
layer_done  out  1  one-cycle pulse after the last pixel is written
overflow  out  1  sticky flag: beat arrived after the map was complete

Behaviour:
- Reset (async, rst=1): all outputs 0, internal state W_IDLE, pixel counter 0, row/col 0.
- Internal FSM states:
  - W_IDLE -> W_RUN when st==CALCULATION.
  - W_RUN -> W_FULL on the accepted beat with pixel count == OUT_DEPTH-1.
  - W_FULL -> W_IDLE when st==IDLE.
- in_ready = (state==W_RUN). It is registered-state derived, with no combinational path from in_valid.
- Accept = in_valid & in_ready.
  - Next cycle: out_we=1, out_addr=pixel count, out_row/out_col = position of that pixel, out_data = ReLU(in_data).
  - Latency is exactly 1 cycle. out_we is 0 on any cycle following a non-accept.
- ReLU, per channel: sign bit 1 -> 0, else pass unchanged. No width change.
- Position update per accept:
  - col+1.
  - When col==OUT_WIDTH-1, col->0 and row+1.
  - Address = row*OUT_WIDTH+col is maintained as an incrementing counter (no multiplier), width 10 bits, wrapping never reached.
- Last pixel (addr 783, row 27, col 27):
  - Write occurs normally.
  - layer_done=1 on the same cycle as that write, for 1 cycle only.
  - State becomes W_FULL.
- W_FULL + in_valid=1: beat dropped, no write, overflow<=1. overflow is sticky until st==IDLE or rst.
- Abort: st leaves CALCULATION while in W_RUN (any code other than CALCULATION).
  - Next cycle the counters, row/col and state clear to W_IDLE.
  - No layer_done. Any write already registered still completes its cycle.
- st==IDLE in any state: counters, overflow and row/col clear. out_we forced 0 the following cycle.
- st==LOAD_W or DONE in W_IDLE: no effect, in_ready=0.
- in_valid with st!=CALCULATION in W_IDLE: ignored, no overflow.
- Re-entry into CALCULATION after W_IDLE restarts at address 0.

Decomposition:
- Shared package (lenet_front_pkg):
  - DATA_WIDTH, OUTPUT_FEATURE_MAP, BUS_WIDTH, OUT_WIDTH, OUT_DEPTH.
  - Controller state codes IDLE/LOAD_W/CALCULATION/DONE, shared with the address generator and controller.
- One sub-module, relu_pack: combinational per-channel ReLU over the packed bus, parameterised by DATA_WIDTH and OUTPUT_FEATURE_MAP.
- FSM and counters stay in the top module.

Test Plan:
- rst pulse mid-cycle with prior activity -> out_we=0, out_addr=0, overflow=0, layer_done=0 immediately, without waiting for a clk edge.
- st=CALCULATION, in_valid held high 784 cycles with in_data channel0 = pixel index -> out_addr 0..783 in order, one cycle later than each beat, out_row/out_col 27/27 at addr 783, layer_done high exactly one cycle, on the addr 783 write.
- Beat with channels {0x7FF, 0x800, 0xFFF, 0x001, 0x000, 0x400} -> out_data channels {0x7FF, 0x000, 0x000, 0x001, 0x000, 0x400}.
- in_valid toggled 1/0 randomly over a full map -> exactly 784 writes, addresses contiguous, col wrap 27->0 with row+1 at addr 28, 56, ..., 756.
- After a full map, 3 extra beats -> no out_we, overflow=1, held; then st=IDLE -> overflow=0.
- Abort at addr 100 (st -> LOAD_W), then st=IDLE, then CALCULATION again -> first write at addr 0, no layer_done during the abort.
